// File: rtl/task_out_packetizer.sv
// Collects result words from the task core into a buffer, then emits them as one
// packet with its byte size and a last marker; long results split into DEPTH-word packets.
module task_out_packetizer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int SIZE_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_input_last,
  output logic                  o_in_ready,
  input  logic                  i_tmanager_ready,
  output logic                  o_tanswer_ready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tanswer_data_last,
  output logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes,
  output logic                  o_busy,
  output logic                  o_full,
  output logic [15:0]           o_pkt_count
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  typedef enum logic {S_LOAD, S_SEND} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d, count_inc;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [15:0]             pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    wr_en, last_word;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    size_d      = size_q;
    pkt_count_d = pkt_count_q;
    wr_en       = 1'b0;
    count_inc   = count_q + CW'(1);
    // count_q holds the latched packet length throughout S_SEND
    last_word   = (state_q == S_SEND) && ({1'b0, rd_ptr_q} == count_q - CW'(1));

    unique case (state_q)
      S_LOAD: begin
        if (i_data_valid) begin
          wr_en   = 1'b1;
          count_d = count_inc;
          if (count_inc == CW'(DEPTH) || i_input_last) begin
            state_d = S_SEND;
            size_d  = SIZE_WIDTH'(count_inc) * SIZE_WIDTH'(BYTES);
          end
        end
      end
      S_SEND: begin
        if (i_tmanager_ready) begin
          if (last_word) begin
            state_d     = S_LOAD;
            count_d     = '0;
            rd_ptr_d    = '0;
            size_d      = '0;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_LOAD;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      size_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      size_q      <= size_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[count_q[PW-1:0]] <= i_data;
  end

  assign o_in_ready             = (state_q == S_LOAD);
  assign o_tanswer_ready        = (state_q == S_SEND);
  assign o_busy                 = (state_q == S_SEND);
  assign o_tdata                = (state_q == S_SEND) ? mem_q[rd_ptr_q] : '0;
  assign o_tanswer_data_last    = last_word;
  assign o_packet_size_in_bytes = size_q;
  assign o_full                 = (count_q == CW'(DEPTH));
  assign o_pkt_count            = pkt_count_q;

endmodule

// File: tb/tb_task_out_packetizer.sv
// Directed and randomized checks of task_out_packetizer against a queue-based packet model.
module tb_task_out_packetizer;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_data_valid;
  logic        i_input_last;
  logic        o_in_ready;
  logic        i_tmanager_ready;
  logic        o_tanswer_ready;
  logic [7:0]  o_tdata;
  logic        o_tanswer_data_last;
  logic [11:0] o_packet_size_in_bytes;
  logic        o_busy;
  logic        o_full;
  logic [15:0] o_pkt_count;

  task_out_packetizer #(.DATA_WIDTH(8), .DEPTH(32), .SIZE_WIDTH(12)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_input_last(i_input_last), .o_in_ready(o_in_ready),
    .i_tmanager_ready(i_tmanager_ready), .o_tanswer_ready(o_tanswer_ready),
    .o_tdata(o_tdata), .o_tanswer_data_last(o_tanswer_data_last),
    .o_packet_size_in_bytes(o_packet_size_in_bytes), .o_busy(o_busy),
    .o_full(o_full), .o_pkt_count(o_pkt_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Model: a packet is the words gathered until DEPTH words or a last marker,
  // then it drains word by word while the manager is ready.
  bit         m_send = 1'b0;
  logic [7:0] m_buf[$];
  int         m_idx = 0;
  logic [15:0] m_pkts = 16'd0;
  logic [7:0] in_stream[$];
  logic [7:0] out_stream[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_data;
    exp_data = m_send ? m_buf[m_idx] : 8'h00;
    chk("in_ready", o_in_ready, !m_send);
    chk("tanswer_ready", o_tanswer_ready, m_send);
    chk("busy", o_busy, m_send);
    chk("tdata", o_tdata, exp_data);
    chk("last", o_tanswer_data_last, m_send && (m_idx == m_buf.size() - 1));
    chk("size", o_packet_size_in_bytes, m_send ? m_buf.size() : 0);
    chk("full", o_full, m_send && (m_buf.size() == 32));
    chk("pkt_count", o_pkt_count, m_pkts);
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit l,
                              input bit r, input bit rst);
    if (rst) begin
      m_send = 1'b0;
      m_buf.delete();
      m_idx  = 0;
      m_pkts = 16'd0;
      in_stream.delete();
      out_stream.delete();
    end else if (!m_send) begin
      if (v) begin
        m_buf.push_back(d);
        in_stream.push_back(d);
        if (m_buf.size() == 32 || l) begin
          m_send = 1'b1;
          m_idx  = 0;
        end
      end
    end else if (r) begin
      if (m_idx == m_buf.size() - 1) begin
        m_send = 1'b0;
        m_buf.delete();
        m_idx  = 0;
        m_pkts = m_pkts + 16'd1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r, input bit rst);
    i_data_valid = v; i_data = d; i_input_last = l; i_tmanager_ready = r; i_rst = rst;
    @(negedge i_clk);
    check_outputs();
    if (!rst && o_tanswer_ready === 1'b1 && r) out_stream.push_back(o_tdata);
    @(posedge i_clk);
    model_update(v, d, l, r, rst);
    #1;
  endtask

  // Waits out any packet in flight (ready random when rnd), then offers one word.
  task automatic feed(input logic [7:0] d, input bit l, input bit rnd);
    for (int g = 0; g < 500 && m_send; g++) step(1'b0, 8'h00, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    chk("feed_wait_bound", o_in_ready, 1'b1);
    step(1'b1, d, l, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
  endtask

  task automatic drain(input bit rnd);
    for (int g = 0; g < 500 && m_send; g++) step(1'b0, 8'h00, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_streams(input string tag);
    int n;
    chk({tag, "_len"}, out_stream.size(), in_stream.size());
    n = (out_stream.size() < in_stream.size()) ? out_stream.size() : in_stream.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, out_stream[i], in_stream[i]);
    in_stream.delete();
    out_stream.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_data = 8'h00; i_data_valid = 1'b0; i_input_last = 1'b0; i_tmanager_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Full-capacity packet 0x00..0x1F
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    chk("cap_full", o_full, 1'b1);
    drain(1'b0);
    chk("cap_pkts", o_pkt_count, 16'd1);
    check_streams("cap");

    // 5-word result 0xA0..0xA4
    for (int i = 0; i < 5; i++) feed(8'hA0 + 8'(i), i == 4, 1'b0);
    chk("five_size", o_packet_size_in_bytes, 12'd5);
    drain(1'b0);
    check_streams("five");

    // Single-word result
    feed(8'h55, 1'b1, 1'b0);
    chk("one_last", o_tanswer_data_last, 1'b1);
    drain(1'b0);
    check_streams("one");

    // 40-word result splits into 32 + 8
    for (int i = 0; i < 40; i++) feed(8'(i + 8'h40), i == 39, 1'b0);
    drain(1'b0);
    chk("split_pkts", o_pkt_count, 16'd5);
    check_streams("split");

    // 8-word packet with manager ready toggling 1,0,0
    for (int i = 0; i < 8; i++) feed(8'hC0 + 8'(i), i == 7, 1'b0);
    for (int c = 0; c < 60 && m_send; c++) step(1'b0, 8'h00, 1'b0, (c % 3) == 0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_streams("stall");

    // Reset after 3 of 10 words sent, then a 4-word packet
    for (int i = 0; i < 10; i++) feed(8'h10 + 8'(i), i == 9, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) feed(8'hE0 + 8'(i), i == 3, 1'b0);
    chk("post_rst_size", o_packet_size_in_bytes, 12'd4);
    drain(1'b0);
    chk("post_rst_pkts", o_pkt_count, 16'd1);
    check_streams("rst");

    // Random results, random gaps and random manager backpressure
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b1 & m_send, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        feed(8'($urandom), i == len - 1, 1'b1);
      end
    end
    drain(1'b1);
    check_streams("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
